// File: rtl/csc_column_sequencer_if.sv
// Handshake bundle between the CSC column sequencer, its address spad and
// the downstream data-spad read pipeline.
interface csc_column_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int COL_WIDTH  = 4
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic                  addr_index_inc;
    logic [ADDR_WIDTH-1:0] data_idx;
    logic [COL_WIDTH-1:0]  data_col;
    logic                  data_last;
    logic                  data_valid;
    logic                  data_ready;
    logic                  col_empty;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [ADDR_WIDTH-1:0] total_nnz;

    modport master (
        input  start, addr_in, data_ready,
        output addr_index_inc, data_idx, data_col, data_last, data_valid,
               col_empty, busy, done, err, total_nnz
    );

    modport slave (
        output start, addr_in, data_ready,
        input  addr_index_inc, data_idx, data_col, data_last, data_valid,
               col_empty, busy, done, err, total_nnz
    );
endinterface

// File: rtl/csc_column_sequencer.sv
// Walks a CSC end-pointer vector from the address spad and emits data-spad
// read indices tagged with their column, flagging empty columns and bad entries.
module csc_column_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int COL_WIDTH  = 4,
    parameter int MAX_COLS   = 11
) (
    input  logic                   clock,
    input  logic                   reset,
    csc_column_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_e;

    localparam logic [COL_WIDTH-1:0] COL_LIMIT = COL_WIDTH'(MAX_COLS);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] prev_end_q, prev_end_d;
    logic [ADDR_WIDTH-1:0] cur_end_q, cur_end_d;
    logic [ADDR_WIDTH-1:0] data_idx_q, data_idx_d;
    logic [ADDR_WIDTH-1:0] total_nnz_q, total_nnz_d;
    logic [COL_WIDTH-1:0]  col_q, col_d;
    logic                  err_q, err_d;
    logic                  last;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            prev_end_q  <= '0;
            cur_end_q   <= '0;
            data_idx_q  <= '0;
            total_nnz_q <= '0;
            col_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_end_q  <= prev_end_d;
            cur_end_q   <= cur_end_d;
            data_idx_q  <= data_idx_d;
            total_nnz_q <= total_nnz_d;
            col_q       <= col_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        prev_end_d         = prev_end_q;
        cur_end_d          = cur_end_q;
        data_idx_d         = data_idx_q;
        total_nnz_d        = total_nnz_q;
        col_d              = col_q;
        err_d              = err_q;
        last               = (data_idx_q == cur_end_q - ADDR_WIDTH'(1));
        bus.addr_index_inc = 1'b0;
        bus.col_empty      = 1'b0;
        bus.data_valid     = 1'b0;
        bus.data_last      = 1'b0;
        bus.done           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = FETCH;
                    prev_end_d = '0;
                    col_d      = '0;
                    err_d      = 1'b0;
                end
            end
            FETCH: begin
                // Priority: terminator, then overflow, then malformed, then empty.
                if (bus.addr_in == '0) begin
                    bus.addr_index_inc = 1'b1;
                    state_d            = DONE;
                end else if (col_q == COL_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (bus.addr_in < prev_end_q) begin
                    err_d              = 1'b1;
                    bus.addr_index_inc = 1'b1;
                end else if (bus.addr_in == prev_end_q) begin
                    bus.addr_index_inc = 1'b1;
                    bus.col_empty      = 1'b1;
                    col_d              = col_q + COL_WIDTH'(1);
                end else begin
                    bus.addr_index_inc = 1'b1;
                    cur_end_d          = bus.addr_in;
                    data_idx_d         = prev_end_q;
                    state_d            = ISSUE;
                end
            end
            ISSUE: begin
                bus.data_valid = 1'b1;
                bus.data_last  = last;
                if (bus.data_ready) begin
                    if (last) begin
                        prev_end_d = cur_end_q;
                        col_d      = col_q + COL_WIDTH'(1);
                        state_d    = FETCH;
                    end else begin
                        data_idx_d = data_idx_q + ADDR_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                bus.done    = 1'b1;
                total_nnz_d = prev_end_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.data_idx  = data_idx_q;
    assign bus.data_col  = col_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.err       = err_q;
    assign bus.total_nnz = total_nnz_q;
endmodule
